// File: rtl/msrv32_integer_file_if.sv
// rtl/msrv32_integer_file_if.sv - read/write port bundle of the msrv32 integer register file
interface msrv32_integer_file_if #(
   parameter int XLEN   = 32,
   parameter int AWIDTH = 5
);
   logic [AWIDTH-1:0] rs_1_addr_in;
   logic [AWIDTH-1:0] rs_2_addr_in;
   logic [AWIDTH-1:0] rd_addr_in;
   logic              wr_en_in;
   logic [XLEN-1:0]   rd_in;
   logic [XLEN-1:0]   rs_1_out;
   logic [XLEN-1:0]   rs_2_out;

   modport master (
      output rs_1_addr_in, rs_2_addr_in, rd_addr_in, wr_en_in, rd_in,
      input  rs_1_out, rs_2_out
   );

   modport slave (
      input  rs_1_addr_in, rs_2_addr_in, rd_addr_in, wr_en_in, rd_in,
      output rs_1_out, rs_2_out
   );
endinterface

// File: rtl/msrv32_integer_file.sv
// rtl/msrv32_integer_file.sv - x0..x31 register file, two combinational read ports, one write port with bypass
module msrv32_integer_file #(
   parameter int XLEN   = 32,
   parameter int AWIDTH = 5
) (
   input logic                  clk_in,
   input logic                  rst_in,
   msrv32_integer_file_if.slave bus
);
   localparam int NREG = 2 ** AWIDTH;

   // x0 has no storage; the array starts at x1
   logic [XLEN-1:0] regs [1:NREG-1];
   logic [XLEN-1:0] rs_1_val;
   logic [XLEN-1:0] rs_2_val;
   logic            wr_ok;
   logic            bypass_1;
   logic            bypass_2;

   assign wr_ok    = bus.wr_en_in && (bus.rd_addr_in != '0) && !rst_in;
   assign bypass_1 = wr_ok && (bus.rd_addr_in == bus.rs_1_addr_in);
   assign bypass_2 = wr_ok && (bus.rd_addr_in == bus.rs_2_addr_in);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 1; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         for (int i = 1; i < NREG; i++) begin
            if (bus.rd_addr_in == AWIDTH'(i)) begin
               regs[i] <= bus.rd_in;
            end
         end
      end
   end

   always_comb begin
      rs_1_val = '0;
      rs_2_val = '0;
      for (int i = 1; i < NREG; i++) begin
         if (bus.rs_1_addr_in == AWIDTH'(i)) begin
            rs_1_val = regs[i];
         end
         if (bus.rs_2_addr_in == AWIDTH'(i)) begin
            rs_2_val = regs[i];
         end
      end
   end

   assign bus.rs_1_out = bypass_1 ? bus.rd_in : rs_1_val;
   assign bus.rs_2_out = bypass_2 ? bus.rd_in : rs_2_val;
endmodule

// File: tb/tb_msrv32_integer_file.sv
// tb/tb_msrv32_integer_file.sv - randomized self-checking bench for msrv32_integer_file
module tb_msrv32_integer_file;
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   logic [31:0] mdl [32];

   msrv32_integer_file_if #(.XLEN(32), .AWIDTH(5)) ifc ();

   msrv32_integer_file #(.XLEN(32), .AWIDTH(5)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (ifc.slave)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (rst_in || a == 5'd0) return 32'h0;
      if (ifc.wr_en_in && ifc.rd_addr_in == a) return ifc.rd_in;
      return mdl[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
   endtask

   task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic wr, input logic [31:0] data);
      ifc.rs_1_addr_in = r1;
      ifc.rs_2_addr_in = r2;
      ifc.rd_addr_in   = rd;
      ifc.wr_en_in     = wr;
      ifc.rd_in        = data;
   endtask

   task automatic check_ports(input string tag);
      chk_value({tag, "_rs1"}, ifc.rs_1_out, model_read(ifc.rs_1_addr_in));
      chk_value({tag, "_rs2"}, ifc.rs_2_out, model_read(ifc.rs_2_addr_in));
   endtask

   // check combinational outputs mid-cycle, clock the write, then update the model
   task automatic cycle(input string tag);
      #1;
      check_ports(tag);
      @(posedge clk_in);
      if (!rst_in && ifc.wr_en_in && ifc.rd_addr_in != 5'd0) mdl[ifc.rd_addr_in] = ifc.rd_in;
      #1;
   endtask

   initial begin
      logic [31:0] a, b;
      model_reset();
      drive(5'd0, 5'd0, 5'd0, 1'b0, 32'h0);

      // reset sweep, with writes attempted that must be discarded
      for (int i = 0; i < 32; i++) begin
         drive(5'(i), 5'(31 - i), 5'(i), 1'b1, $urandom);
         #1;
         chk_value("reset_rs1", ifc.rs_1_out, 32'h0);
         chk_value("reset_rs2", ifc.rs_2_out, 32'h0);
         @(posedge clk_in);
         #1;
      end
      @(negedge clk_in);
      rst_in = 1'b0;
      drive(5'd5, 5'd6, 5'd5, 1'b0, 32'h0);
      cycle("post_reset");

      drive(5'd5, 5'd6, 5'd5, 1'b1, 32'hDEAD_BEEF);
      cycle("wr_x5");
      drive(5'd5, 5'd6, 5'd0, 1'b0, 32'h0);
      #1;
      chk_value("x5_read", ifc.rs_1_out, 32'hDEAD_BEEF);
      chk_value("x6_read", ifc.rs_2_out, 32'h0);
      cycle("x5_hold");

      drive(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF);
      #1;
      chk_value("x0_during", ifc.rs_1_out, 32'h0);
      cycle("x0_wr");
      drive(5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
      #1;
      chk_value("x0_after", ifc.rs_1_out, 32'h0);

      drive(5'd7, 5'd7, 5'd7, 1'b1, 32'd20);
      cycle("x7_init");
      drive(5'd7, 5'd7, 5'd7, 1'b1, 32'd60);
      #1;
      chk_value("bypass_rs1", ifc.rs_1_out, 32'd60);
      chk_value("bypass_rs2", ifc.rs_2_out, 32'd60);
      cycle("bypass");
      drive(5'd7, 5'd7, 5'd0, 1'b0, 32'h0);
      #1;
      chk_value("bypass_after1", ifc.rs_1_out, 32'd60);
      chk_value("bypass_after2", ifc.rs_2_out, 32'd60);

      // ALU chain: operands read from the file, arithmetic done here
      drive(5'd1, 5'd2, 5'd1, 1'b1, 32'd20);
      cycle("x1");
      drive(5'd1, 5'd2, 5'd2, 1'b1, 32'd40);
      cycle("x2");
      drive(5'd1, 5'd2, 5'd0, 1'b0, 32'h0);
      #1;
      a = ifc.rs_1_out;
      b = ifc.rs_2_out;
      chk_value("alu_add", a + b, 32'd60);
      chk_value("alu_sub", a - b, 32'hFFFF_FFEC);
      drive(5'd3, 5'd0, 5'd3, 1'b1, a + b);
      cycle("x3_wr");
      drive(5'd3, 5'd0, 5'd0, 1'b0, 32'h0);
      #1;
      chk_value("x3_read", ifc.rs_1_out, 32'd60);

      drive(5'd9, 5'd9, 5'd9, 1'b1, 32'h1234_5678);
      cycle("x9_wr");
      drive(5'd9, 5'd9, 5'd0, 1'b0, 32'h0);
      #1;
      chk_value("x9_pre", ifc.rs_1_out, 32'h1234_5678);
      #1;
      rst_in = 1'b1;
      model_reset();
      #1;
      chk_value("x9_async_clr", ifc.rs_1_out, 32'h0);
      rst_in = 1'b0;
      drive(5'd9, 5'd4, 5'd9, 1'b1, 32'hCAFE_0001);
      cycle("x9_post_wr");
      drive(5'd9, 5'd4, 5'd0, 1'b0, 32'h0);
      #1;
      chk_value("x9_landed", ifc.rs_1_out, 32'hCAFE_0001);
      chk_value("x4_cleared", ifc.rs_2_out, 32'h0);

      // randomized traffic with occasional mid-cycle reset pulses
      for (int n = 0; n < 600; n++) begin
         drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), $urandom);
         if ($urandom_range(0, 7) == 0) ifc.rs_1_addr_in = ifc.rd_addr_in;
         if ($urandom_range(0, 7) == 0) ifc.rs_2_addr_in = ifc.rd_addr_in;
         if ($urandom_range(0, 79) == 0) begin
            rst_in = 1'b1;
            model_reset();
            #1;
            check_ports("rand_rst");
            rst_in = 1'b0;
         end
         cycle("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
